// File: rtl/cmsdk_ahb_addr_trace.sv
// cmsdk_ahb_addr_trace
// Passive AHB-Lite address-phase tracer. Every accepted transfer (NONSEQ/SEQ
// with HREADY high) whose address lies inside [ADDR_LO, ADDR_HI] is pushed
// into a small register FIFO. A debug host drains the FIFO over a valid/ready
// stream. The tracer never drives the bus and never back-pressures it: a push
// into a full FIFO without a simultaneous pop is dropped and counted.
//
// Optional build macro: ARM_CMSDK_TRACE_TSTAMP_EN
//   defined   -> a free-running 16-bit cycle counter is stored with each record
//                and presented on trace_tstamp
//   undefined -> no counter, no timestamp storage, trace_tstamp = 16'h0000
module cmsdk_ahb_addr_trace #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] ADDR_LO    = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI    = 32'hFFFF_FFFF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADY,
  input  logic                  trace_en,
  input  logic                  trace_clear,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_addr,
  output logic                  trace_write,
  output logic [2:0]            trace_size,
  output logic [15:0]           trace_tstamp,
  output logic [DEPTH_LOG2:0]   trace_count,
  output logic                  trace_overflow,
  output logic [15:0]           trace_drops
);

  localparam int                   DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [15:0]           r_drops;

  logic [31:0] r_mem_addr  [DEPTH];
  logic        r_mem_write [DEPTH];
  logic [2:0]  r_mem_size  [DEPTH];

  logic [32:0] w_lo_diff;
  logic [32:0] w_hi_diff;
  logic        w_in_win;
  logic        w_cap;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_unused;

  // Window test done as 33-bit borrows so the default full-range window
  // does not collapse into constant comparisons.
  assign w_lo_diff = {1'b0, HADDR} - {1'b0, ADDR_LO};
  assign w_hi_diff = {1'b0, ADDR_HI} - {1'b0, HADDR};
  assign w_in_win  = ~w_lo_diff[32] & ~w_hi_diff[32];

  // HTRANS[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
  assign w_cap   = trace_en & HREADY & HTRANS[1] & w_in_win;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = ~w_empty & trace_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

  assign w_unused = ^{HTRANS[0], w_lo_diff[31:0], w_hi_diff[31:0]};

  // FIFO pointers, occupancy and drop status; clear overrides push/pop.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || trace_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drops    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
      end
    end
  end

  // Record storage; data slots need no reset because occupancy guards them.
  always_ff @(posedge HCLK) begin
    if (w_push && !trace_clear) begin
      r_mem_addr[r_wr_ptr]  <= HADDR;
      r_mem_write[r_wr_ptr] <= HWRITE;
      r_mem_size[r_wr_ptr]  <= HSIZE;
    end
  end

`ifdef ARM_CMSDK_TRACE_TSTAMP_EN
  logic [15:0] r_tstamp;
  logic [15:0] r_mem_ts [DEPTH];

  // Free-running cycle counter; only reset clears it, not trace_clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_tstamp <= '0;
    end else begin
      r_tstamp <= r_tstamp + 16'd1;
    end
  end

  // Timestamp slot written alongside the rest of the record.
  always_ff @(posedge HCLK) begin
    if (w_push && !trace_clear) begin
      r_mem_ts[r_wr_ptr] <= r_tstamp;
    end
  end

  assign trace_tstamp = w_empty ? 16'h0000 : r_mem_ts[r_rd_ptr];
`else
  assign trace_tstamp = 16'h0000;
`endif

  assign trace_valid    = ~w_empty;
  assign trace_addr     = w_empty ? 32'h0 : r_mem_addr[r_rd_ptr];
  assign trace_write    = w_empty ? 1'b0  : r_mem_write[r_rd_ptr];
  assign trace_size     = w_empty ? 3'b0  : r_mem_size[r_rd_ptr];
  assign trace_count    = r_count;
  assign trace_overflow = r_overflow;
  assign trace_drops    = r_drops;

endmodule

// File: tb/tb_cmsdk_ahb_addr_trace.sv
// Bench for cmsdk_ahb_addr_trace: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_cmsdk_ahb_addr_trace;

  localparam int          DL2   = 2;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [31:0] LO    = 32'h2000_0000;
  localparam logic [31:0] HI    = 32'h2000_FFFF;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic          trace_en;
  logic          trace_clear;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_addr;
  logic          trace_write;
  logic [2:0]    trace_size;
  logic [15:0]   trace_tstamp;
  logic [DL2:0]  trace_count;
  logic          trace_overflow;
  logic [15:0]   trace_drops;

  cmsdk_ahb_addr_trace #(.DEPTH_LOG2(DL2), .ADDR_LO(LO), .ADDR_HI(HI)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .trace_en(trace_en),
    .trace_clear(trace_clear), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_write(trace_write), .trace_size(trace_size),
    .trace_tstamp(trace_tstamp), .trace_count(trace_count),
    .trace_overflow(trace_overflow), .trace_drops(trace_drops)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [2:0]  s;
    logic [15:0] t;
  } rec_t;

  rec_t        q[$];
  bit          m_ov;
  int          m_drops;
  logic [15:0] m_ts;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_ts(input logic [15:0] t);
`ifdef ARM_CMSDK_TRACE_TSTAMP_EN
    return t;
`else
    return 16'h0000 & t;
`endif
  endfunction

  // Reference behaviour applied at each rising edge from the sampled inputs.
  task automatic model_edge();
    bit   cap, pop, full;
    rec_t r;
    if (!HRESETn) begin
      q.delete(); m_ov = 0; m_drops = 0; m_ts = 16'h0;
    end else begin
      if (trace_clear) begin
        q.delete(); m_ov = 0; m_drops = 0;
      end else begin
        cap  = trace_en && HREADY && HTRANS[1] && HADDR >= LO && HADDR <= HI;
        pop  = (q.size() != 0) && trace_ready;
        full = (q.size() == DEPTH);
        r.a = HADDR; r.w = HWRITE; r.s = HSIZE; r.t = m_ts;
        if (pop) void'(q.pop_front());
        if (cap) begin
          if (!full || pop) q.push_back(r);
          else begin
            m_ov = 1;
            if (m_drops < 65535) m_drops++;
          end
        end
      end
      m_ts = m_ts + 16'd1;
    end
  endtask

  task automatic check_all();
    rec_t h;
    h.a = 32'h0; h.w = 1'b0; h.s = 3'h0; h.t = 16'h0;
    if (q.size() != 0) h = q[0];
    chk("valid",    32'(trace_valid),    32'(q.size() != 0));
    chk("count",    32'(trace_count),    32'(q.size()));
    chk("overflow", 32'(trace_overflow), 32'(m_ov));
    chk("drops",    32'(trace_drops),    32'(m_drops));
    chk("addr",     trace_addr,          h.a);
    chk("write",    32'(trace_write),    32'(h.w));
    chk("size",     32'(trace_size),     32'(h.s));
    chk("tstamp",   32'(trace_tstamp),   32'(exp_ts(h.t)));
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic bus(input logic [31:0] a, input logic [1:0] tr, input logic w, input logic rdy);
    HADDR = a; HTRANS = tr; HWRITE = w; HSIZE = 3'd2; HREADY = 1'b1; trace_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    bus(32'h0, 2'b00, 1'b0, rdy);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return LO - 32'd4;
      1: return LO;
      2: return HI;
      3: return HI + 32'd1;
      4: return LO + ($urandom & 32'h0000_FFFC);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_list [6];
    logic [15:0] t1, t2;
    int g;

    HRESETn = 1'b0; trace_en = 1'b1; trace_clear = 1'b0; idle(1'b0);
    m_ts = 16'h0; m_ov = 0; m_drops = 0;
    repeat (3) tick();
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_count", 32'(trace_count), 32'd0);
    chk("rst_ovf",   32'(trace_overflow), 32'd0);
    chk("rst_drops", 32'(trace_drops), 32'd0);
    HRESETn = 1'b1;

    // three consecutive reads drained as they arrive
    for (int i = 0; i < 3; i++) begin
      bus(LO + 32'(i * 4), 2'b10, 1'b0, 1'b1);
      tick();
      chk("t1_valid", 32'(trace_valid), 32'd1);
      chk("t1_cnt_le1", 32'(trace_count <= 1), 32'd1);
      chk("t1_addr", trace_addr, LO + 32'(i * 4));
    end
    idle(1'b1); tick();
    chk("t1_empty", 32'(trace_valid), 32'd0);

    // window boundaries
    a_list[0] = 32'h1FFF_FFFC; a_list[1] = 32'h2000_0000;
    a_list[2] = 32'h2000_FFFF; a_list[3] = 32'h2001_0000;
    for (int i = 0; i < 4; i++) begin
      bus(a_list[i], 2'b10, 1'b1, 1'b0); tick();
    end
    idle(1'b0); tick();
    chk("t2_count", 32'(trace_count), 32'd2);
    chk("t2_head0", trace_addr, 32'h2000_0000);
    chk("t2_write", 32'(trace_write), 32'd1);
    idle(1'b1); tick();
    chk("t2_head1", trace_addr, 32'h2000_FFFF);
    tick();
    chk("t2_empty", 32'(trace_count), 32'd0);

    // overflow: six captures into four slots
    for (int i = 0; i < 6; i++) begin
      a_list[i] = LO + 32'h100 + 32'(i * 8);
      bus(a_list[i], 2'b10, 1'b0, 1'b0); tick();
    end
    idle(1'b0); tick();
    chk("t3_count", 32'(trace_count), 32'd4);
    chk("t3_ovf",   32'(trace_overflow), 32'd1);
    chk("t3_drops", 32'(trace_drops), 32'd2);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain", trace_addr, a_list[i]);
      tick();
    end

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 5; i++) a_list[i] = LO + 32'h400 + 32'(i * 4);
    for (int i = 0; i < 4; i++) begin
      bus(a_list[i], 2'b10, 1'b0, 1'b0); tick();
    end
    bus(a_list[4], 2'b11, 1'b0, 1'b1); tick();
    chk("t4_count", 32'(trace_count), 32'd4);
    chk("t4_drops", 32'(trace_drops), 32'd2);
    idle(1'b1);
    for (int i = 1; i < 5; i++) begin
      chk("t4_drain", trace_addr, a_list[i]);
      tick();
    end
    chk("t4_empty", 32'(trace_valid), 32'd0);

    // wait states, BUSY/IDLE, clear colliding with a capture
    bus(LO + 32'h800, 2'b10, 1'b0, 1'b0); HREADY = 1'b0;
    repeat (3) tick();
    HREADY = 1'b1; tick();
    idle(1'b0); tick();
    chk("t5_one", 32'(trace_count), 32'd1);
    idle(1'b1); tick();
    bus(LO + 32'h804, 2'b01, 1'b0, 1'b0); tick();
    bus(LO + 32'h808, 2'b00, 1'b0, 1'b0); tick();
    chk("t5_none", 32'(trace_count), 32'd0);
    bus(LO + 32'h810, 2'b10, 1'b0, 1'b0); repeat (2) tick();
    trace_clear = 1'b1; tick();
    trace_clear = 1'b0; idle(1'b0);
    chk("t5_clr_cnt", 32'(trace_count), 32'd0);
    chk("t5_clr_ovf", 32'(trace_overflow), 32'd0);
    chk("t5_clr_drp", 32'(trace_drops), 32'd0);
    tick();
    chk("t5_clr_val", 32'(trace_valid), 32'd0);

    // timestamp delta of captures five cycles apart
    bus(LO + 32'hA00, 2'b10, 1'b0, 1'b0); tick();
    t1 = trace_tstamp;
    idle(1'b0); repeat (4) tick();
    bus(LO + 32'hA04, 2'b10, 1'b0, 1'b0); tick();
    idle(1'b1); tick();
    t2 = trace_tstamp;
`ifdef ARM_CMSDK_TRACE_TSTAMP_EN
    chk("t6_delta", 32'(t2 - t1), 32'd5);
`else
    chk("t6_delta", 32'(t2 - t1), 32'd0);
`endif
    tick();

    // disabling capture keeps draining
    bus(LO + 32'hB00, 2'b10, 1'b0, 1'b0); repeat (2) tick();
    trace_en = 1'b0; repeat (2) tick();
    chk("t7_hold", 32'(trace_count), 32'd2);
    idle(1'b1); repeat (2) tick();
    chk("t7_drained", 32'(trace_count), 32'd0);
    trace_en = 1'b1;

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      HADDR       = rand_addr();
      HTRANS      = 2'($urandom);
      HWRITE      = 1'($urandom);
      HSIZE       = 3'($urandom);
      HREADY      = ($urandom_range(0, 3) != 0);
      trace_en    = ($urandom_range(0, 9) != 0);
      trace_clear = ($urandom_range(0, 29) == 0);
      trace_ready = 1'($urandom);
      HRESETn     = ($urandom_range(0, 199) != 0);
      tick();
    end
    HRESETn = 1'b1; trace_en = 1'b1; trace_clear = 1'b0;

    // reset while holding records
    bus(LO + 32'hC00, 2'b10, 1'b0, 1'b0); repeat (3) tick();
    HRESETn = 1'b0; tick();
    HRESETn = 1'b1; idle(1'b0);
    chk("t9_count", 32'(trace_count), 32'd0);
    chk("t9_valid", 32'(trace_valid), 32'd0);

    // flood towards the timestamp wrap
    bus(LO + 32'hD00, 2'b10, 1'b0, 1'b0);
    g = 0;
    while (m_ts != 16'hFFF0 && g < 70000) begin tick(); g++; end
    chk("t10_reach", 32'(m_ts), 32'h0000_FFF0);
    idle(1'b1); repeat (DEPTH) tick();
    idle(1'b0);
    g = 0;
    while (m_ts != 16'hFFFE && g < 100) begin tick(); g++; end
    bus(LO + 32'hE00, 2'b10, 1'b0, 1'b0); tick();
    chk("t10_ts_fffe", 32'(trace_tstamp), 32'(exp_ts(16'hFFFE)));
    idle(1'b0); repeat (4) tick();
    bus(LO + 32'hE04, 2'b10, 1'b0, 1'b0); tick();
    chk("t10_cnt2", 32'(trace_count), 32'd2);
    idle(1'b1); tick();
    chk("t10_ts_0003", 32'(trace_tstamp), 32'(exp_ts(16'h0003)));
    tick();

    // drop counter saturation
    bus(LO + 32'hF00, 2'b10, 1'b0, 1'b0);
    g = 0;
    while (m_drops < 65535 && g < 70000) begin tick(); g++; end
    repeat (3) tick();
    chk("t11_sat", 32'(trace_drops), 32'h0000_FFFF);
    chk("t11_ovf", 32'(trace_overflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
